// File: rtl/xmtfifo_pkg.sv
// Shared constants and drain-FSM state encoding for the transmit byte FIFO.
package xmtfifo_pkg;

    localparam int unsigned XMT_DEPTH_LOG2 = 4;
    localparam int unsigned XMT_BYTE_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } xmt_state_e;

endpackage

// File: rtl/xmtfifo_ram.sv
// Storage array for xmtfifo: one synchronous write port, one asynchronous read port.
module xmtfifo_ram
    import xmtfifo_pkg::*;
#(
    parameter int unsigned ADDR_W = XMT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [XMT_BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [XMT_BYTE_W-1:0] rdata
);

    logic [XMT_BYTE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/xmtfifo.sv
// Transmit byte FIFO draining into the transmitter buffer's write/ready handshake.
// Define XMTFIFO_FLUSH_EN to enable the synchronous flush input.
module xmtfifo
    import xmtfifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = XMT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [XMT_BYTE_W-1:0] wr_data,
    input  logic                  flush,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  xmt_write,
    output logic [XMT_BYTE_W-1:0] xmt_data,
    input  logic                  xmt_ready,
    input  logic                  xmt_empty,
    output logic                  all_empty
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [XMT_BYTE_W-1:0] rd_data;
    xmt_state_e            state;
    logic                  flush_hit;
    logic                  push;
    logic                  pop;

`ifdef XMTFIFO_FLUSH_EN
    assign flush_hit = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_hit    = 1'b0;
`endif

    // count never exceeds the depth, so its MSB alone marks the full condition
    assign full      = count[DEPTH_LOG2];
    assign push      = wr_en & ~full & ~flush_hit;
    assign pop       = (state == ST_IDLE) & (count != '0) & xmt_ready & ~flush_hit;
    assign all_empty = (count == '0) & (state == ST_IDLE) & xmt_empty;

    xmtfifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_hit) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // WAIT covers the cycle in which the buffer's ready still shows its pre-write value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            xmt_write <= 1'b0;
            xmt_data  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        xmt_data  <= rd_data;
                        xmt_write <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    xmt_write <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    xmt_write <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xmtfifo.sv
// Directed and randomized bench for xmtfifo against a queue-based reference model.
module tb_xmtfifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       flush = 1'b0;
    logic       xmt_ready = 1'b0;
    logic       xmt_empty = 1'b1;
    logic       full;
    logic [4:0] count;
    logic       xmt_write;
    logic [7:0] xmt_data;
    logic       all_empty;

    int         vectors = 0;
    int         miscompares = 0;

    // Reference model: queue contents, cycles left in the post-issue lockout, last issued byte
    logic [7:0] q[$];
    logic [7:0] acc[$];
    logic [7:0] sent[$];
    int         gap = 0;
    logic [7:0] exp_data = '0;
    int         tx_busy = 0;

    xmtfifo #(
        .DEPTH_LOG2 (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .full      (full),
        .count     (count),
        .xmt_write (xmt_write),
        .xmt_data  (xmt_data),
        .xmt_ready (xmt_ready),
        .xmt_empty (xmt_empty),
        .all_empty (all_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("xmt_write", 32'(xmt_write), 32'(gap == 2));
        chk("xmt_data", 32'(xmt_data), 32'(exp_data));
        chk("all_empty", 32'(all_empty), 32'(q.size() == 0 && gap == 0 && xmt_empty));
    endtask

    // Apply current inputs across one rising edge, advance the model, compare
    task automatic cycle();
        bit pushok, popok, fl;
        fl = 1'b0;
`ifdef XMTFIFO_FLUSH_EN
        fl = flush;
`endif
        pushok = wr_en && (q.size() < DEPTH) && !fl;
        popok  = (gap == 0) && (q.size() != 0) && xmt_ready && !fl;
        @(posedge clk);
        #1;
        if (gap > 0) gap--;
        if (popok) begin
            exp_data = q.pop_front();
            sent.push_back(exp_data);
            gap = 2;
        end
        if (fl) begin
            q.delete();
        end else if (pushok) begin
            q.push_back(wr_data);
            acc.push_back(wr_data);
        end
        check_outputs();
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_len"}, 32'(sent.size()), 32'(acc.size()));
        for (int i = 0; i < acc.size() && i < sent.size(); i++) begin
            chk({tag, "_byte"}, 32'(sent[i]), 32'(acc[i]));
        end
    endtask

    initial begin
        int last_strobe;
        bit prev_ready;

        // Reset state
        #2;
        check_outputs();
        xmt_empty = 1'b0;
        #1;
        chk("rst_all_empty", 32'(all_empty), 32'(0));
        xmt_empty = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single byte
        acc.delete(); sent.delete();
        xmt_ready = 1'b1;
        wr_data = 8'h41; wr_en = 1'b1;
        cycle();
        wr_en = 1'b0;
        cycle();
        chk("single_strobe", 32'(xmt_write), 32'(1));
        chk("single_data", 32'(xmt_data), 32'h41);
        xmt_empty = 1'b0;
        repeat (3) cycle();
        xmt_empty = 1'b1;
        cycle();
        chk("single_all_empty", 32'(all_empty), 32'(1));

        // Fill to full, drop 17th, then drain in order
        acc.delete(); sent.delete();
        xmt_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            cycle();
        end
        wr_data = 8'hFF;
        cycle();
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_count", 32'(count), 32'(16));
        wr_en = 1'b0;
        xmt_ready = 1'b1;
        repeat (60) cycle();
        chk("fill_len", 32'(sent.size()), 32'(16));
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            chk("fill_order", 32'(sent[i]), 32'(i));
        end

        // Backpressure with a busy transmitter buffer model
        acc.delete(); sent.delete();
        last_strobe = -10;
        for (int c = 0; c < 3200; c++) begin
            if (acc.size() >= 100) wr_en = 1'b0;
            else wr_en = 1'($urandom_range(0, 1));
            wr_data   = 8'($urandom);
            xmt_ready = (tx_busy == 0);
            xmt_empty = (tx_busy == 0);
            prev_ready = xmt_ready;
            cycle();
            if (xmt_write) begin
                chk("bp_strobe_vs_ready", 32'(prev_ready), 32'(1));
                chk("bp_spacing", 32'((c - last_strobe) >= 3), 32'(1));
                last_strobe = c;
            end
            if (gap == 2) tx_busy = $urandom_range(1, 4);
            else if (tx_busy > 0) tx_busy--;
            if (acc.size() >= 100 && q.size() == 0 && gap == 0 && c > 400) break;
        end
        chk("bp_accepted", 32'(acc.size()), 32'(100));
        compare_logs("bp");

        // Steady push and pop, pointers wrap
        acc.delete(); sent.delete();
        tx_busy = 0;
        xmt_ready = 1'b1; xmt_empty = 1'b1;
        for (int i = 0; i < 123; i++) begin
            wr_en   = (i % 3 == 0) && (i / 3 < 41);
            wr_data = 8'($urandom);
            cycle();
        end
        wr_en = 1'b0;
        repeat (6) cycle();
        compare_logs("wrap");

        // Flush with simultaneous push
        xmt_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            cycle();
        end
        chk("flush_pre_count", 32'(count), 32'(7));
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hAA; xmt_ready = 1'b1;
        cycle();
`ifdef XMTFIFO_FLUSH_EN
        chk("flush_count", 32'(count), 32'(0));
`else
        chk("flush_ignored_count", 32'(count), 32'(7));
`endif
        flush = 1'b0; wr_en = 1'b0;
        repeat (40) cycle();

        // Reset mid-drain with count=5
        xmt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            cycle();
        end
        wr_en = 1'b0; xmt_ready = 1'b1;
        cycle();
        chk("rst_pre_count", 32'(count), 32'(5));
        #2;
        rst_n = 1'b0;
        #1;
        q.delete(); gap = 0; exp_data = '0;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        repeat (10) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
